riscv_obi_mem_arbiter: RTL and testbench
========================================

// Module: riscv_obi_mem_arbiter
// PURPOSE
//  Shares one single-ported OBI memory between the core's instruction (port 0) and data (port 1) interfaces.
//  Sits between the per-port grant-stall perturbation blocks and the testbench RAM.
//  Provides round-robin arbitration with OBI address-phase locking.
//  Routes each response back to its requester via an in-order outstanding-owner FIFO.
// PARAMETERS
//  ADDR_WIDTH       32  address width, both sides
//  DATA_WIDTH       32  data width; BE width = DATA_WIDTH/8
//  MAX_OUTSTANDING  2   max accepted-but-unanswered transfers (>=1)
// PORTS
//  clk_i             in   1        clock
//  rst_ni            in   1        async active-low reset
//  req_i             in   2        per-port request ([0]=instr, [1]=data)
//  gnt_o             out  2        per-port grant
//  addr_i            in   2xADDR   per-port address
//  we_i              in   2        per-port write enable
//  be_i              in   2xDW/8   per-port byte enables
//  wdata_i           in   2xDW     per-port write data
//  rvalid_o          out  2        per-port response valid
//  rdata_o           out  2xDW     per-port read data (rdata_o[p] driven = mem rdata_i for both p)
//  mem_req_o         out  1        memory request
//  mem_gnt_i         in   1        memory grant
//  mem_addr_o/we_o/be_o/wdata_o out  muxed address-phase signals of the selected port
//  mem_rvalid_i      in   1        memory response valid
//  mem_rdata_i       in   DW       memory read data
//  err_o             out  1        sticky protocol error (rvalid with empty FIFO)
// BEHAVIOUR
//  Reset: gnt_o=0, rvalid_o=0, mem_req_o=0, err_o=0, FIFO empty, rr_prio=port 0, no lock.
//  Selection (combinational):
//   - If lock valid: sel=lock owner.
//   - Else if only one port requests: sel=that port.
//   - Else if both request: sel=rr_prio.
//  mem_req_o = req_i[sel] & !fifo_full; mem_addr/we/be/wdata = port sel.
//  gnt_o[sel] = mem_gnt_i & mem_req_o; other port gnt=0. Zero added latency.
//  Accept = mem_req_o & mem_gnt_i: push sel into FIFO; rr_prio <= ~sel; clear lock.
//  Lock: mem_req_o high without gnt -> lock <= sel, held until that port's accept.
//   - OBI forbids dropping req before gnt, so the selected address phase stays stable.
//   - If the locked port drops req anyway: clear lock, set err_o.
//  FIFO full: mem_req_o forced 0 even when a pop occurs the same cycle (conservative, no comb path rvalid->req).
//  Response: mem_rvalid_i pops FIFO head h; rvalid_o[h]=1 same cycle (combinational); rvalid_o[~h]=0.
//   - In-order memory assumed; response may arrive the cycle after accept at the earliest.
//  Simultaneous push+pop when not full: both apply, count unchanged.
//  mem_rvalid_i with FIFO empty: no rvalid_o, err_o <= 1 (sticky until reset).
//  Counter width $clog2(MAX_OUTSTANDING+1); pointers wrap modulo MAX_OUTSTANDING.
//  Reset mid-transfer: all state cleared asynchronously; late memory responses then flag err_o.
// STRUCTURE
//  Shared tb package: typedef enum logic {OBI_PORT_INSTR=0, OBI_PORT_DATA=1} obi_port_e.
//  Sub-module riscv_obi_owner_fifo (1-bit wide, DEPTH=MAX_OUTSTANDING): push/pop/full/empty/head.
//  Top holds the selection/lock/rr logic and error flag.
// TESTING
//  1 Only port0 reqs addr 0x100, mem_gnt=1, rvalid next cycle
//    -> gnt_o=01 same cycle, rvalid_o=01 one cycle later.
//  2 Both req every cycle, gnt always 1 -> grants alternate 01,10,01,10...
//    -> rvalid owners match the grant order.
//  3 Port1 reqs, mem_gnt=0 for 3 cycles, port0 reqs at cycle 1
//    -> mem_addr stays port1's for all 4 cycles; port1 granted cycle 3; port0 granted next.
//  4 MAX_OUTSTANDING=2, two accepts with no rvalid -> mem_req_o=0 while full.
//    -> First rvalid pops; the next request is accepted the following cycle.
//  5 mem_rvalid_i pulse with FIFO empty -> rvalid_o=00, err_o=1 and held.
//  6 Assert rst_ni low with 2 outstanding -> outputs at reset values.
//    -> After release, fresh req is accepted, count=1.

Source files
------------

// File: rtl/riscv_obi_mem_arbiter_pkg.sv
// Shared types and sizing helpers for the two-port OBI memory arbiter.
// Port 0 is the instruction interface, port 1 the data interface.
package riscv_obi_mem_arbiter_pkg;

    typedef enum logic {
        OBI_PORT_INSTR = 1'b0,
        OBI_PORT_DATA  = 1'b1
    } obi_port_e;

    localparam int unsigned NUM_PORTS = 2;

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Pointer increment that wraps at depth, so non-power-of-two depths work.
    function automatic logic [31:0] wrap_inc(input logic [31:0] ptr, input int unsigned depth);
        return (ptr == 32'(depth - 1)) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/riscv_obi_owner_fifo.sv
// In-order FIFO of response owners: one entry per accepted-but-unanswered transfer.
// Push is ignored when full and pop is ignored when empty.
module riscv_obi_owner_fifo
    import riscv_obi_mem_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    input  logic      i_push,
    input  obi_port_e i_din,
    input  logic      i_pop,
    output logic      o_full,
    output logic      o_empty,
    output obi_port_e o_head
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);
    localparam int unsigned CNT_W = cnt_width(DEPTH);

    obi_port_e        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rptr];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= OBI_PORT_INSTR;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr] <= i_din;
                r_wptr        <= PTR_W'(wrap_inc(32'(r_wptr), DEPTH));
            end
            if (w_do_pop) begin
                r_rptr <= PTR_W'(wrap_inc(32'(r_rptr), DEPTH));
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/riscv_obi_mem_arbiter.sv
// Round-robin arbiter sharing one OBI memory between instruction and data ports,
// with address-phase locking and in-order response routing.
module riscv_obi_mem_arbiter
    import riscv_obi_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [NUM_PORTS-1:0]                  req_i,
    output logic [NUM_PORTS-1:0]                  gnt_o,
    input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  addr_i,
    input  logic [NUM_PORTS-1:0]                  we_i,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0] be_i,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  wdata_i,
    output logic [NUM_PORTS-1:0]                  rvalid_o,
    output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  rdata_o,
    output logic                                  mem_req_o,
    input  logic                                  mem_gnt_i,
    output logic [ADDR_WIDTH-1:0]                 mem_addr_o,
    output logic                                  mem_we_o,
    output logic [DATA_WIDTH/8-1:0]               mem_be_o,
    output logic [DATA_WIDTH-1:0]                 mem_wdata_o,
    input  logic                                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]                 mem_rdata_i,
    output logic                                  err_o
);

    obi_port_e r_rr_prio;
    obi_port_e r_lock_owner;
    logic      r_lock_vld;
    logic      r_err;

    obi_port_e w_sel;
    obi_port_e w_head;
    logic      w_sel_bit;
    logic      w_head_bit;
    logic      w_lock_bit;
    logic      w_fifo_full;
    logic      w_fifo_empty;
    logic      w_accept;
    logic      w_pop;
    logic      w_lock_drop;

    // A pending lock pins the selection so the presented address phase stays stable.
    always_comb begin
        w_sel = OBI_PORT_INSTR;
        if (r_lock_vld) begin
            w_sel = r_lock_owner;
        end else if (req_i == 2'b11) begin
            w_sel = r_rr_prio;
        end else if (req_i[1]) begin
            w_sel = OBI_PORT_DATA;
        end
    end

    assign w_sel_bit  = w_sel;
    assign w_head_bit = w_head;
    assign w_lock_bit = r_lock_owner;

    // Full blocks requests even on a same-cycle pop, keeping rvalid off the req path.
    assign mem_req_o   = req_i[w_sel_bit] & ~w_fifo_full;
    assign mem_addr_o  = addr_i[w_sel_bit];
    assign mem_we_o    = we_i[w_sel_bit];
    assign mem_be_o    = be_i[w_sel_bit];
    assign mem_wdata_o = wdata_i[w_sel_bit];

    assign w_accept    = mem_req_o & mem_gnt_i;
    assign w_pop       = mem_rvalid_i & ~w_fifo_empty;
    assign w_lock_drop = r_lock_vld & ~req_i[w_lock_bit];

    always_comb begin
        gnt_o            = '0;
        gnt_o[w_sel_bit] = w_accept;
    end

    always_comb begin
        rvalid_o             = '0;
        rvalid_o[w_head_bit] = w_pop;
    end

    assign rdata_o[0] = mem_rdata_i;
    assign rdata_o[1] = mem_rdata_i;
    assign err_o      = r_err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_prio    <= OBI_PORT_INSTR;
            r_lock_owner <= OBI_PORT_INSTR;
            r_lock_vld   <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            if (w_accept) begin
                r_rr_prio  <= obi_port_e'(~w_sel_bit);
                r_lock_vld <= 1'b0;
            end else if (w_lock_drop) begin
                r_lock_vld <= 1'b0;
            end else if (mem_req_o) begin
                r_lock_vld   <= 1'b1;
                r_lock_owner <= w_sel;
            end
            if (w_lock_drop || (mem_rvalid_i && w_fifo_empty)) begin
                r_err <= 1'b1;
            end
        end
    end

    riscv_obi_owner_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_owner_fifo (
        .i_clk   (clk_i),
        .i_rst_n (rst_ni),
        .i_push  (w_accept),
        .i_din   (w_sel),
        .i_pop   (w_pop),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_head  (w_head)
    );

endmodule

// File: tb/tb_riscv_obi_mem_arbiter.sv
// Directed bench for riscv_obi_mem_arbiter: a per-cycle vector table plus
// hand-written reset and lock-drop sequences.
module tb_riscv_obi_mem_arbiter;

    localparam logic [31:0] A0 = 32'h0000_0100;
    localparam logic [31:0] A1 = 32'h0000_0200;
    localparam logic [31:0] W1 = 32'hCAFE_F00D;

    logic             clk;
    logic             rst_n;
    logic [1:0]       req;
    logic [1:0]       gnt;
    logic [1:0][31:0] addr;
    logic [1:0]       we;
    logic [1:0][3:0]  be;
    logic [1:0][31:0] wdata;
    logic [1:0]       rvalid;
    logic [1:0][31:0] rdata;
    logic             mem_req;
    logic             mem_gnt;
    logic [31:0]      mem_addr;
    logic             mem_we;
    logic [3:0]       mem_be;
    logic [31:0]      mem_wdata;
    logic             mem_rvalid;
    logic [31:0]      mem_rdata;
    logic             err;

    int n_checks = 0;
    int n_pass   = 0;

    logic [0:0] exp_q[$];

    typedef struct {
        logic [1:0] req;
        logic       mgnt;
        logic       mrv;
        logic [1:0] e_gnt;
        logic [1:0] e_rv;
        logic       e_mreq;
        logic       e_port;
        logic       e_err;
    } vec_t;

    vec_t vecs[24];

    riscv_obi_mem_arbiter #(
        .ADDR_WIDTH      (32),
        .DATA_WIDTH      (32),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_i        (req),
        .gnt_o        (gnt),
        .addr_i       (addr),
        .we_i         (we),
        .be_i         (be),
        .wdata_i      (wdata),
        .rvalid_o     (rvalid),
        .rdata_o      (rdata),
        .mem_req_o    (mem_req),
        .mem_gnt_i    (mem_gnt),
        .mem_addr_o   (mem_addr),
        .mem_we_o     (mem_we),
        .mem_be_o     (mem_be),
        .mem_wdata_o  (mem_wdata),
        .mem_rvalid_i (mem_rvalid),
        .mem_rdata_i  (mem_rdata),
        .err_o        (err)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic [1:0] r, input logic g, input logic rv,
                                input logic [1:0] eg, input logic [1:0] erv,
                                input logic emr, input logic ep, input logic ee);
        vec_t v;
        v.req = r; v.mgnt = g; v.mrv = rv;
        v.e_gnt = eg; v.e_rv = erv; v.e_mreq = emr; v.e_port = ep; v.e_err = ee;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Driver: inputs change just after the rising edge, checks run at the falling edge.
    task automatic step(input logic [1:0] r, input logic g, input logic rv);
        @(posedge clk);
        #1;
        req        = r;
        mem_gnt    = g;
        mem_rvalid = rv;
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 32'd0);
        chk({tag, "_rvalid"}, 32'(rvalid), 32'd0);
        chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #3;
        req        = 2'b00;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        rst_n      = 1'b0;
        #1;
        check_idle(tag);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        req        = 2'b00;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        addr[0]    = A0;   addr[1]  = A1;
        we[0]      = 1'b0; we[1]    = 1'b1;
        be[0]      = 4'hF; be[1]    = 4'h3;
        wdata[0]   = 32'h0; wdata[1] = W1;

        //              req    g     rv    e_gnt  e_rv   mreq  port  err
        vecs[0]  = mk(2'b01, 1'b1, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0);
        vecs[1]  = mk(2'b00, 1'b1, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0);
        vecs[2]  = mk(2'b11, 1'b1, 1'b0, 2'b10, 2'b00, 1'b1, 1'b1, 1'b0);
        vecs[3]  = mk(2'b11, 1'b1, 1'b1, 2'b01, 2'b10, 1'b1, 1'b0, 1'b0);
        vecs[4]  = mk(2'b11, 1'b1, 1'b1, 2'b10, 2'b01, 1'b1, 1'b1, 1'b0);
        vecs[5]  = mk(2'b11, 1'b1, 1'b1, 2'b01, 2'b10, 1'b1, 1'b0, 1'b0);
        vecs[6]  = mk(2'b10, 1'b1, 1'b1, 2'b10, 2'b01, 1'b1, 1'b1, 1'b0);
        vecs[7]  = mk(2'b00, 1'b1, 1'b1, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0);
        vecs[8]  = mk(2'b10, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
        vecs[9]  = mk(2'b11, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
        vecs[10] = mk(2'b11, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
        vecs[11] = mk(2'b11, 1'b1, 1'b0, 2'b10, 2'b00, 1'b1, 1'b1, 1'b0);
        vecs[12] = mk(2'b01, 1'b1, 1'b1, 2'b01, 2'b10, 1'b1, 1'b0, 1'b0);
        vecs[13] = mk(2'b00, 1'b1, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0);
        vecs[14] = mk(2'b01, 1'b1, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0);
        vecs[15] = mk(2'b01, 1'b1, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0);
        vecs[16] = mk(2'b01, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        vecs[17] = mk(2'b01, 1'b1, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0);
        vecs[18] = mk(2'b01, 1'b1, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0);
        vecs[19] = mk(2'b00, 1'b1, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0);
        vecs[20] = mk(2'b00, 1'b1, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0);
        vecs[21] = mk(2'b00, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        vecs[22] = mk(2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
        vecs[23] = mk(2'b01, 1'b1, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b1);

        // Power-on reset values
        #2;
        check_idle("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 24; i++) begin
            string t;
            logic [0:0] owner;
            t = $sformatf("v%0d", i);
            step(vecs[i].req, vecs[i].mgnt, vecs[i].mrv);
            chk({t, "_gnt"}, 32'(gnt), 32'(vecs[i].e_gnt));
            chk({t, "_rvalid"}, 32'(rvalid), 32'(vecs[i].e_rv));
            chk({t, "_mem_req"}, 32'(mem_req), 32'(vecs[i].e_mreq));
            chk({t, "_mem_addr"}, mem_addr, vecs[i].e_port ? A1 : A0);
            chk({t, "_mem_we"}, 32'(mem_we), 32'(vecs[i].e_port));
            chk({t, "_mem_wdata"}, mem_wdata, vecs[i].e_port ? W1 : 32'h0);
            chk({t, "_err"}, 32'(err), 32'(vecs[i].e_err));
            // Scoreboard: each response must go to the oldest still-unanswered grant owner.
            if (rvalid != 2'b00) begin
                if (exp_q.size() == 0) begin
                    chk({t, "_sb_unexpected_rvalid"}, 32'(rvalid), 32'd0);
                end else begin
                    owner = exp_q.pop_front();
                    chk({t, "_sb_owner"}, 32'(rvalid), owner[0] ? 32'd2 : 32'd1);
                end
            end
            if (vecs[i].e_gnt != 2'b00) exp_q.push_back(vecs[i].e_gnt[1]);
        end

        // Reset with two transfers outstanding, then a fresh transfer behaves as count=1.
        step(2'b01, 1'b1, 1'b0);
        chk("rst_pre_gnt", 32'(gnt), 32'd1);
        do_reset("rst_mid");
        step(2'b11, 1'b1, 1'b0);
        chk("rst_fresh_gnt", 32'(gnt), 32'd1);
        chk("rst_fresh_mem_addr", mem_addr, A0);
        mem_rdata = 32'hA5A5_0001;
        step(2'b00, 1'b1, 1'b1);
        chk("rst_resp_rvalid", 32'(rvalid), 32'd1);
        chk("rst_rdata0", rdata[0], 32'hA5A5_0001);
        chk("rst_rdata1", rdata[1], 32'hA5A5_0001);
        chk("rst_resp_err", 32'(err), 32'd0);
        step(2'b00, 1'b1, 1'b1);
        chk("rst_extra_rvalid", 32'(rvalid), 32'd0);
        step(2'b00, 1'b1, 1'b0);
        chk("rst_extra_err", 32'(err), 32'd1);

        // Locked port withdrawing its request is a protocol error.
        do_reset("rst_lock");
        step(2'b10, 1'b0, 1'b0);
        chk("lock_mem_req", 32'(mem_req), 32'd1);
        chk("lock_mem_addr", mem_addr, A1);
        chk("lock_gnt", 32'(gnt), 32'd0);
        step(2'b01, 1'b0, 1'b0);
        chk("lock_drop_mem_req", 32'(mem_req), 32'd0);
        chk("lock_drop_err_now", 32'(err), 32'd0);
        step(2'b01, 1'b1, 1'b0);
        chk("lock_drop_err", 32'(err), 32'd1);
        chk("lock_after_gnt", 32'(gnt), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
